// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scanner: shows a latched 32-bit value as hex,
// advancing one digit per rising edge of the (asynchronous) scan clock.
module seg7_scan_driver #(
    parameter int BLANK_CYCLES = 2,    // dark clk cycles after each digit advance, 0..15
    parameter bit LZ_SUPPRESS  = 1'b0  // 1 = blank leading zero digits (digit 0 always shown)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_clk,
    input  logic        load,
    input  logic [31:0] data_in,
    input  logic [7:0]  digit_mask_in,
    input  logic [7:0]  dp_in,
    output logic [7:0]  led_en,
    output logic [6:0]  led_seg,
    output logic        led_dp
);

    logic        s1_q, s2_q, s3_q;
    logic        adv;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;
    logic [7:0]  mask_q, mask_d;
    logic [3:0]  blank_q, blank_d;
    logic [7:0]  led_en_q, led_en_d;
    logic [6:0]  led_seg_q, led_seg_d;
    logic        led_dp_q, led_dp_d;
    logic [3:0]  nibble;
    logic        lz_blank;
    logic        digit_off;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] seg;
        case (n)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Scan state: a held-high scan_clk gives a single adv because s3 tracks s2.
    always_comb begin
        adv     = s2_q & ~s3_q;
        idx_d   = idx_q;
        blank_d = blank_q;
        data_d  = data_q;
        mask_d  = mask_q;
        if (adv) begin
            idx_d   = idx_q + 3'd1;
            blank_d = 4'(BLANK_CYCLES);
        end else if (blank_q != 4'd0) begin
            blank_d = blank_q - 4'd1;
        end
        if (load) begin
            data_d = data_in;
            mask_d = digit_mask_in;
        end
    end

    always_comb begin
        nibble   = data_q[{idx_q, 2'b00} +: 4];
        lz_blank = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (3'(j) >= idx_q && data_q[4*j +: 4] != 4'd0) begin
                lz_blank = 1'b0;
            end
        end
        digit_off = (blank_q != 4'd0) || !mask_q[idx_q] ||
                    (LZ_SUPPRESS && idx_q != 3'd0 && lz_blank);
        if (digit_off) begin
            led_en_d  = 8'hFF;
            led_seg_d = 7'h7F;
            led_dp_d  = 1'b1;
        end else begin
            led_en_d  = ~(8'b1 << idx_q);
            led_seg_d = decode(nibble);
            led_dp_d  = ~dp_in[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            idx_q     <= 3'd0;
            blank_q   <= 4'd0;
            data_q    <= 32'd0;
            mask_q    <= 8'h00;
            led_en_q  <= 8'hFF;
            led_seg_q <= 7'h7F;
            led_dp_q  <= 1'b1;
        end else begin
            s1_q      <= scan_clk;
            s2_q      <= s1_q;
            s3_q      <= s2_q;
            idx_q     <= idx_d;
            blank_q   <= blank_d;
            data_q    <= data_d;
            mask_q    <= mask_d;
            led_en_q  <= led_en_d;
            led_seg_q <= led_seg_d;
            led_dp_q  <= led_dp_d;
        end
    end

    assign led_en  = led_en_q;
    assign led_seg = led_seg_q;
    assign led_dp  = led_dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a default instance (BLANK_CYCLES=2) and a
// second instance with BLANK_CYCLES=0, LZ_SUPPRESS=1 share all inputs.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        scan_clk;
    logic        load;
    logic [31:0] data_in;
    logic [7:0]  digit_mask_in;
    logic [7:0]  dp_in;
    logic [7:0]  led_en, lz_en;
    logic [6:0]  led_seg, lz_seg;
    logic        led_dp, lz_dp;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] cap;

    always #5 clk = ~clk;

    seg7_scan_driver dut (
        .clk(clk), .rst(rst), .scan_clk(scan_clk), .load(load), .data_in(data_in),
        .digit_mask_in(digit_mask_in), .dp_in(dp_in),
        .led_en(led_en), .led_seg(led_seg), .led_dp(led_dp)
    );

    seg7_scan_driver #(.BLANK_CYCLES(0), .LZ_SUPPRESS(1'b1)) dut_lz (
        .clk(clk), .rst(rst), .scan_clk(scan_clk), .load(load), .data_in(data_in),
        .digit_mask_in(digit_mask_in), .dp_in(dp_in),
        .led_en(lz_en), .led_seg(lz_seg), .led_dp(lz_dp)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_main(input string tag, input logic [7:0] en, input logic [6:0] seg,
                            input logic dp);
        chk(tag, {led_en, led_seg, led_dp}, {en, seg, dp});
        chk({tag, "_onehot"}, {15'd0, $countones(~led_en) <= 1}, 16'd1);
    endtask

    task automatic chk_lz(input string tag, input logic [7:0] en, input logic [6:0] seg,
                          input logic dp);
        chk(tag, {lz_en, lz_seg, lz_dp}, {en, seg, dp});
    endtask

    // One scan_clk rising edge; leaves the bench at the first lit cycle of the default DUT.
    // cap holds the zero-blank instance's outputs one edge after the advance.
    task automatic pulse(input logic do_load, input logic [31:0] ld_data);
        scan_clk = 1'b0;
        repeat (3) tick();
        scan_clk = 1'b1;
        tick();
        tick();
        if (do_load) begin
            load    = 1'b1;
            data_in = ld_data;
        end
        tick();
        load = 1'b0;
        tick();
        cap = {lz_en, lz_seg, lz_dp};
        chk_main("blank_t1", 8'hFF, 7'h7F, 1'b1);
        tick();
        chk_main("blank_t2", 8'hFF, 7'h7F, 1'b1);
        tick();
    endtask

    task automatic step(input string tag, input logic [7:0] en, input logic [6:0] seg,
                        input logic dp, input logic [7:0] zen, input logic [6:0] zseg,
                        input logic zdp);
        pulse(1'b0, 32'd0);
        chk_main(tag, en, seg, dp);
        chk({tag, "_lz"}, cap, {zen, zseg, zdp});
    endtask

    task automatic load_val(input logic [31:0] d, input logic [7:0] m);
        load          = 1'b1;
        data_in       = d;
        digit_mask_in = m;
        tick();
        load = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b1; scan_clk = 1'b0; load = 1'b0;
        data_in = 32'd0; digit_mask_in = 8'h00; dp_in = 8'h00;
        repeat (5) tick();
        chk_main("reset", 8'hFF, 7'h7F, 1'b1);
        chk_lz("reset_lz", 8'hFF, 7'h7F, 1'b1);
        rst = 1'b0;

        // Idle scanning with no load stays dark; eight advances return idx to 0.
        for (int i = 0; i < 8; i++) step("idle", 8'hFF, 7'h7F, 1'b1, 8'hFF, 7'h7F, 1'b1);

        // Full scan of 89ABCDEF
        load_val(32'h89ABCDEF, 8'hFF);
        chk_main("fs_d0_pre", 8'hFE, 7'h0E, 1'b1);
        step("fs_d1", 8'hFD, 7'h06, 1'b1, 8'hFD, 7'h06, 1'b1);
        step("fs_d2", 8'hFB, 7'h21, 1'b1, 8'hFB, 7'h21, 1'b1);
        step("fs_d3", 8'hF7, 7'h46, 1'b1, 8'hF7, 7'h46, 1'b1);
        step("fs_d4", 8'hEF, 7'h03, 1'b1, 8'hEF, 7'h03, 1'b1);
        step("fs_d5", 8'hDF, 7'h08, 1'b1, 8'hDF, 7'h08, 1'b1);
        step("fs_d6", 8'hBF, 7'h10, 1'b1, 8'hBF, 7'h10, 1'b1);
        step("fs_d7", 8'h7F, 7'h00, 1'b1, 8'h7F, 7'h00, 1'b1);
        step("fs_d0", 8'hFE, 7'h0E, 1'b1, 8'hFE, 7'h0E, 1'b1);

        // Mask and decimal point: nibble0=2, nibble1=1, dp on digit 1 only
        dp_in = 8'h02;
        load_val(32'h00000012, 8'h03);
        chk_main("md_d0_pre", 8'hFE, 7'h24, 1'b1);
        chk_lz("md_d0_pre_lz", 8'hFE, 7'h24, 1'b1);
        step("md_d1", 8'hFD, 7'h79, 1'b0, 8'hFD, 7'h79, 1'b0);
        for (int i = 2; i < 8; i++) step("md_dark", 8'hFF, 7'h7F, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("md_d0", 8'hFE, 7'h24, 1'b1, 8'hFE, 7'h24, 1'b1);
        dp_in = 8'h00;

        // Leading-zero suppression: all zeros
        load_val(32'h00000000, 8'hFF);
        chk_main("lz0_d0_pre", 8'hFE, 7'h40, 1'b1);
        chk_lz("lz0_d0_pre_lz", 8'hFE, 7'h40, 1'b1);
        step("lz0_d1", 8'hFD, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lz0_d2", 8'hFB, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lz0_d3", 8'hF7, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lz0_d4", 8'hEF, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lz0_d5", 8'hDF, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lz0_d6", 8'hBF, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lz0_d7", 8'h7F, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lz0_d0", 8'hFE, 7'h40, 1'b1, 8'hFE, 7'h40, 1'b1);

        // Leading-zero suppression: 00A00000 keeps digits 0..5
        load_val(32'h00A00000, 8'hFF);
        step("lza_d1", 8'hFD, 7'h40, 1'b1, 8'hFD, 7'h40, 1'b1);
        step("lza_d2", 8'hFB, 7'h40, 1'b1, 8'hFB, 7'h40, 1'b1);
        step("lza_d3", 8'hF7, 7'h40, 1'b1, 8'hF7, 7'h40, 1'b1);
        step("lza_d4", 8'hEF, 7'h40, 1'b1, 8'hEF, 7'h40, 1'b1);
        step("lza_d5", 8'hDF, 7'h08, 1'b1, 8'hDF, 7'h08, 1'b1);
        step("lza_d6", 8'hBF, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lza_d7", 8'h7F, 7'h40, 1'b1, 8'hFF, 7'h7F, 1'b1);
        step("lza_d0", 8'hFE, 7'h40, 1'b1, 8'hFE, 7'h40, 1'b1);

        // scan_clk held high for 100 cycles advances exactly once
        load_val(32'h76543210, 8'hFF);
        chk_main("hold_pre", 8'hFE, 7'h40, 1'b1);
        scan_clk = 1'b0;
        repeat (3) tick();
        scan_clk = 1'b1;
        repeat (100) tick();
        chk_main("hold_d1", 8'hFD, 7'h79, 1'b1);
        chk_lz("hold_d1_lz", 8'hFD, 7'h79, 1'b1);
        step("hold_next", 8'hFB, 7'h24, 1'b1, 8'hFB, 7'h24, 1'b1);

        // load in the same cycle as adv: new digit 3 shows the new nibble (B)
        pulse(1'b1, 32'hFEDCBA98);
        chk_main("ldadv_d3", 8'hF7, 7'h03, 1'b1);
        chk("ldadv_d3_lz", cap, {8'hF7, 7'h03, 1'b1});
        step("pre_rst_d4", 8'hEF, 7'h46, 1'b1, 8'hEF, 7'h46, 1'b1);
        step("pre_rst_d5", 8'hDF, 7'h21, 1'b1, 8'hDF, 7'h21, 1'b1);

        // Asynchronous reset at idx=5
        #2 rst = 1'b1;
        #1;
        chk_main("rst_async", 8'hFF, 7'h7F, 1'b1);
        chk_lz("rst_async_lz", 8'hFF, 7'h7F, 1'b1);
        scan_clk = 1'b0;
        tick();
        chk_main("rst_hold", 8'hFF, 7'h7F, 1'b1);
        rst = 1'b0;
        repeat (3) tick();
        chk_main("post_rst_dark", 8'hFF, 7'h7F, 1'b1);
        load_val(32'h76543210, 8'hFF);
        chk_main("post_rst_d0", 8'hFE, 7'h40, 1'b1);
        chk_lz("post_rst_d0_lz", 8'hFE, 7'h40, 1'b1);
        step("post_rst_d1", 8'hFD, 7'h79, 1'b1, 8'hFD, 7'h79, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
